// File: rtl/spi_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_regfile
//  Description : SPI slave endpoint for the 41-bit bridge frame
//                {wr_rd[40], addr[39:32], data[31:0]}, sent MSB first.
//                Write frames update the local register file. Read frames
//                return register data on MISO during data bits 31..0.
//                SPI signals share the SCLK domain, so they are edge-detected
//                directly and are not synchronized.
//  Parameters  : DEPTH   - registers implemented at addr 0..DEPTH-1 (1..256)
//                RST_VAL - reset value of every register
//  Macro       : SPI_SLAVE_STATUS_EN - when defined, addr 8'hFF is a
//                read-only status word {frame_err_cnt, good_frame_cnt}.
//  Ports       : SCLK, SRESET          - system clock, sync active-high reset
//                spi_clk/cs/mosi/miso  - SPI slave pins (cs active low)
//                reg_wr_en/addr/data   - 1-cycle pulse for a completed write
//                frame_err             - 1-cycle pulse, frame length != 41
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_regfile #(
    parameter int          DEPTH   = 16,
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic        SCLK,
    input  logic        SRESET,
    input  logic        spi_clk,
    input  logic        spi_cs,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        reg_wr_en,
    output logic [7:0]  reg_wr_addr,
    output logic [31:0] reg_wr_data,
    output logic        frame_err
);
    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] C_DEPTH  = 9'(DEPTH);
    localparam logic [5:0] C_FULL   = 6'd41;
    localparam logic [5:0] C_SAT    = 6'd42;
    localparam logic [5:0] C_LASTAD = 6'd8;
    localparam logic [5:0] C_LASTRD = 6'd40;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_ADDR, S_DATA} state_t;

    state_t      state_q, state_d;
    logic        clk_q, cs_q;
    logic [5:0]  bit_cnt_q, bit_cnt_d, cnt_now;
    logic        wr_rd_q, wr_rd_d;
    logic [7:0]  addr_q, addr_d, nxt_addr;
    logic [31:0] wdata_q, wdata_d, rd_word;
    logic [30:0] rd_sh_q, rd_sh_d;
    logic        spi_miso_q, spi_miso_d;
    logic        reg_wr_en_q, reg_wr_en_d;
    logic [7:0]  reg_wr_addr_q, reg_wr_addr_d;
    logic [31:0] reg_wr_data_q, reg_wr_data_d;
    logic        frame_err_q, frame_err_d;
    logic [31:0] regs_q [DEPTH];
    logic [31:0] regs_d [DEPTH];
    logic        bit_v, eof, writable;
`ifdef SPI_SLAVE_STATUS_EN
    logic [15:0] good_cnt_q, good_cnt_d, err_cnt_q, err_cnt_d;
`endif

    assign spi_miso    = spi_miso_q;
    assign reg_wr_en   = reg_wr_en_q;
    assign reg_wr_addr = reg_wr_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign frame_err   = frame_err_q;

    // Read lookup for the address completed by the bit being accepted now.
    always_comb begin
        nxt_addr = {addr_q[6:0], spi_mosi};
        rd_word  = 32'h0;
        if ({1'b0, nxt_addr} < C_DEPTH) begin
            rd_word = regs_q[nxt_addr[AW-1:0]];
        end
`ifdef SPI_SLAVE_STATUS_EN
        if (nxt_addr == 8'hFF) begin
            rd_word = {err_cnt_q, good_cnt_q};
        end
`endif
    end

    always_comb begin
        bit_v         = clk_q & ~spi_clk & ~cs_q;
        eof           = spi_cs & ~cs_q;
        cnt_now       = bit_cnt_q;
        writable      = 1'b0;
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        wr_rd_d       = wr_rd_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rd_sh_d       = rd_sh_q;
        spi_miso_d    = spi_miso_q;
        reg_wr_en_d   = 1'b0;
        reg_wr_addr_d = 8'h0;
        reg_wr_data_d = 32'h0;
        frame_err_d   = 1'b0;
        regs_d        = regs_q;
`ifdef SPI_SLAVE_STATUS_EN
        good_cnt_d    = good_cnt_q;
        err_cnt_d     = err_cnt_q;
`endif
        if (state_q == S_IDLE) begin
            spi_miso_d = 1'b0;
            bit_cnt_d  = 6'd0;
            // Only a fresh cs fall opens a frame: a frame still in flight
            // when reset releases is ignored until cs has gone high again.
            if (~spi_cs & cs_q) begin
                state_d = S_CMD;
            end
        end else begin
            if (bit_v) begin
                if (bit_cnt_q != C_SAT) begin
                    cnt_now = bit_cnt_q + 6'd1;
                end
                case (state_q)
                    S_CMD: begin
                        wr_rd_d = spi_mosi;
                        state_d = S_ADDR;
                    end
                    S_ADDR: begin
                        addr_d = nxt_addr;
                        if (bit_cnt_q == C_LASTAD) begin
                            // Bit 31 goes out now; bits 30..0 shift out on
                            // the following data-bit falls.
                            rd_sh_d    = rd_word[30:0];
                            spi_miso_d = ~wr_rd_q & rd_word[31];
                            state_d    = S_DATA;
                        end
                    end
                    default: begin
                        if (bit_cnt_q < C_LASTRD) begin
                            wdata_d    = {wdata_q[30:0], spi_mosi};
                            spi_miso_d = ~wr_rd_q & rd_sh_q[30];
                            rd_sh_d    = {rd_sh_q[29:0], 1'b0};
                        end else if (bit_cnt_q == C_LASTRD) begin
                            wdata_d    = {wdata_q[30:0], spi_mosi};
                            spi_miso_d = 1'b0;
                        end
                    end
                endcase
            end
            bit_cnt_d = cnt_now;
            // eof is evaluated after the same-cycle bit has been folded in.
            if (eof) begin
                state_d    = S_IDLE;
                bit_cnt_d  = 6'd0;
                spi_miso_d = 1'b0;
                if (cnt_now == C_FULL) begin
`ifdef SPI_SLAVE_STATUS_EN
                    if (good_cnt_q != 16'hFFFF) good_cnt_d = good_cnt_q + 16'd1;
`endif
                    if (wr_rd_d) begin
                        reg_wr_en_d   = 1'b1;
                        reg_wr_addr_d = addr_d;
                        reg_wr_data_d = wdata_d;
                        writable      = ({1'b0, addr_d} < C_DEPTH);
`ifdef SPI_SLAVE_STATUS_EN
                        if (addr_d == 8'hFF) writable = 1'b0;
`endif
                        if (writable) begin
                            regs_d[addr_d[AW-1:0]] = wdata_d;
                        end
                    end
                end else begin
                    frame_err_d = 1'b1;
`ifdef SPI_SLAVE_STATUS_EN
                    if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
`endif
                end
            end
        end
    end

    always_ff @(posedge SCLK) begin
        if (SRESET) begin
            clk_q         <= 1'b0;
            cs_q          <= 1'b0;
            state_q       <= S_IDLE;
            bit_cnt_q     <= 6'd0;
            wr_rd_q       <= 1'b0;
            addr_q        <= 8'h0;
            wdata_q       <= 32'h0;
            rd_sh_q       <= 31'h0;
            spi_miso_q    <= 1'b0;
            reg_wr_en_q   <= 1'b0;
            reg_wr_addr_q <= 8'h0;
            reg_wr_data_q <= 32'h0;
            frame_err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= RST_VAL;
`ifdef SPI_SLAVE_STATUS_EN
            good_cnt_q    <= 16'h0;
            err_cnt_q     <= 16'h0;
`endif
        end else begin
            clk_q         <= spi_clk;
            cs_q          <= spi_cs;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            wr_rd_q       <= wr_rd_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rd_sh_q       <= rd_sh_d;
            spi_miso_q    <= spi_miso_d;
            reg_wr_en_q   <= reg_wr_en_d;
            reg_wr_addr_q <= reg_wr_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            frame_err_q   <= frame_err_d;
            regs_q        <= regs_d;
`ifdef SPI_SLAVE_STATUS_EN
            good_cnt_q    <= good_cnt_d;
            err_cnt_q     <= err_cnt_d;
`endif
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_spi_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_regfile
//  Description : Self-checking bench for spi_slave_regfile. A transaction-
//                level register model predicts write pulses, frame errors
//                and read data; a per-cycle compare process checks them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_regfile;
    localparam int          DEPTH   = 16;
    localparam logic [31:0] RST_VAL = 32'hA5A5_0F0F;
    localparam int          H       = 3;

    logic        SCLK = 1'b0;
    logic        SRESET, spi_clk, spi_cs, spi_mosi;
    logic        spi_miso, reg_wr_en, frame_err;
    logic [7:0]  reg_wr_addr;
    logic [31:0] reg_wr_data;

    spi_slave_regfile #(.DEPTH(DEPTH), .RST_VAL(RST_VAL)) dut (
        .SCLK(SCLK), .SRESET(SRESET), .spi_clk(spi_clk), .spi_cs(spi_cs),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .reg_wr_en(reg_wr_en),
        .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .frame_err(frame_err)
    );

    always #5 SCLK = ~SCLK;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [31:0] mdl [256];
    logic [15:0] m_goods, m_errs;
    logic        ex_en = 1'b0, ex_err = 1'b0, miso_chk = 1'b0, ex_miso = 1'b0;
    logic [7:0]  ex_addr = 8'h0;
    logic [31:0] ex_data = 32'h0;
    logic        chk_on = 1'b0;
    logic [7:0]  last_addr = 8'h0;
    logic [31:0] last_data = 32'h0;
    int          idle_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge SCLK);
        #1;
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] a);
`ifdef SPI_SLAVE_STATUS_EN
        if (a == 8'hFF) return {m_errs, m_goods};
`endif
        if (int'(a) < DEPTH) return mdl[a];
        return 32'h0;
    endfunction

    task automatic m_reset;
        for (int a = 0; a < 256; a++) mdl[a] = RST_VAL;
        m_goods = 16'h0;
        m_errs  = 16'h0;
    endtask

    task automatic do_reset;
        SRESET = 1'b1;
        tick;
        SRESET = 1'b0;
        m_reset();
        tick;
    endtask

    // One compare process: pulses every cycle, MISO where a data bit is due,
    // and MISO quiet once cs has been high for a few cycles.
    always @(negedge SCLK) begin
        if (chk_on) begin
            chk("reg_wr_en", {31'h0, reg_wr_en}, {31'h0, ex_en});
            if (ex_en) begin
                chk("reg_wr_addr", {24'h0, reg_wr_addr}, {24'h0, ex_addr});
                chk("reg_wr_data", reg_wr_data, ex_data);
            end
            chk("frame_err", {31'h0, frame_err}, {31'h0, ex_err});
            if (miso_chk) chk("miso_bit", {31'h0, spi_miso}, {31'h0, ex_miso});
            if (spi_cs) idle_cnt++; else idle_cnt = 0;
            if (idle_cnt >= 3) chk("miso_idle", {31'h0, spi_miso}, 32'h0);
            if (reg_wr_en) begin
                last_addr = reg_wr_addr;
                last_data = reg_wr_data;
            end
            ex_en  = 1'b0;
            ex_err = 1'b0;
        end
    end

    // Master-side frame: MOSI changes on rise, slave samples on fall.
    // rst_at >= 0 pulses SRESET during that bit; gap is cs-high cycles after.
    task automatic send_frame(input logic [40:0] f, input int nbits, input int rst_at,
                              input int gap, output logic [31:0] cap);
        logic        rd, aborted;
        logic [31:0] word;
        rd      = ~f[40];
        word    = m_read(f[39:32]);
        aborted = 1'b0;
        cap     = 32'h0;
        spi_cs  = 1'b0;
        repeat (2) tick;
        for (int i = 0; i < nbits; i++) begin
            spi_clk  = 1'b1;
            spi_mosi = (i < 41) ? f[40-i] : 1'($urandom);
            repeat (H) tick;
            if (i == rst_at) begin
                SRESET = 1'b1;
                tick;
                SRESET = 1'b0;
                m_reset();
                aborted = 1'b1;
            end
            if (!aborted && i >= 9 && i <= 40) begin
                ex_miso  = rd ? word[40-i] : 1'b0;
                miso_chk = 1'b1;
                tick;
                miso_chk = 1'b0;
                cap[40-i] = spi_miso;
            end
            spi_clk = 1'b0;
            repeat (H) tick;
        end
        spi_cs = 1'b1;
        tick;
        if (!aborted) begin
            if (nbits == 41) begin
                if (m_goods != 16'hFFFF) m_goods++;
                if (f[40]) begin
                    ex_en   = 1'b1;
                    ex_addr = f[39:32];
                    ex_data = f[31:0];
`ifdef SPI_SLAVE_STATUS_EN
                    if (f[39:32] != 8'hFF && int'(f[39:32]) < DEPTH) mdl[f[39:32]] = f[31:0];
`else
                    if (int'(f[39:32]) < DEPTH) mdl[f[39:32]] = f[31:0];
`endif
                end
            end else begin
                if (m_errs != 16'hFFFF) m_errs++;
                ex_err = 1'b1;
            end
        end
        repeat (gap - 1) tick;
    endtask

    task automatic idle_toggle;
        repeat (3) begin
            spi_clk = 1'b1;
            repeat (2) tick;
            spi_clk = 1'b0;
            repeat (2) tick;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cap;
        logic [40:0] f;
        int          nb;
        logic [7:0]  a;
        SRESET = 1'b1; spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
        m_reset();
        repeat (3) tick;
        SRESET = 1'b0;
        tick;
        chk("rst_miso", {31'h0, spi_miso}, 32'h0);
        chk("rst_wr_en", {31'h0, reg_wr_en}, 32'h0);
        chk("rst_wr_addr", {24'h0, reg_wr_addr}, 32'h0);
        chk("rst_wr_data", reg_wr_data, 32'h0);
        chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
        chk_on = 1'b1;

        send_frame({1'b1, 8'h05, 32'hDEADBEEF}, 41, -1, 4, cap);
        repeat (2) tick;
        chk("wr05_addr", {24'h0, last_addr}, 32'h05);
        chk("wr05_data", last_data, 32'hDEADBEEF);
        send_frame({1'b0, 8'h05, 32'h0}, 41, -1, 4, cap);
        chk("rd05", cap, 32'hDEADBEEF);
        send_frame({1'b0, 8'h03, 32'h0}, 41, -1, 4, cap);
        chk("rd03_rstval", cap, 32'hA5A5_0F0F);
        send_frame({1'b0, 8'h40, 32'hFFFF_FFFF}, 41, -1, 4, cap);
        chk("rd40_oor", cap, 32'h0);

        send_frame({1'b1, 8'h06, 32'h1111_2222}, 20, -1, 4, cap);
        send_frame({1'b0, 8'h06, 32'h0}, 41, -1, 4, cap);
        chk("rd06_after_short", cap, 32'hA5A5_0F0F);

        send_frame({1'b1, 8'h02, 32'hCAFE_F00D}, 41, 30, 4, cap);
        send_frame({1'b0, 8'h02, 32'h0}, 41, -1, 4, cap);
        chk("rd02_after_reset", cap, 32'hA5A5_0F0F);

        send_frame({1'b1, 8'h07, 32'h1234_5678}, 41, -1, 1, cap);
        send_frame({1'b0, 8'h07, 32'h0}, 41, -1, 4, cap);
        chk("rd07_b2b", cap, 32'h1234_5678);

        idle_toggle();
        do_reset();
        send_frame({1'b1, 8'h01, 32'h0000_0001}, 41, -1, 2, cap);
        send_frame({1'b1, 8'h02, 32'h0000_0002}, 41, -1, 2, cap);
        send_frame({1'b0, 8'h01, 32'h0}, 41, -1, 2, cap);
        chk("rd01", cap, 32'h0000_0001);
        send_frame({1'b1, 8'h03, 32'h0000_0003}, 12, -1, 2, cap);
        send_frame({1'b0, 8'hFF, 32'h0}, 41, -1, 4, cap);
`ifdef SPI_SLAVE_STATUS_EN
        chk("rd_status", cap, 32'h0001_0003);
`else
        chk("rd_ff_oor", cap, 32'h0);
`endif

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       a = 8'hFF;
                1:       a = 8'($urandom_range(0, 255));
                default: a = 8'($urandom_range(0, DEPTH - 1));
            endcase
            f  = {1'($urandom), a, 32'($urandom)};
            nb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 45) : 41;
            send_frame(f, nb, -1, $urandom_range(1, 4), cap);
            if ($urandom_range(0, 7) == 0) idle_toggle();
        end
        repeat (8) tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
